oric_ram_arbiter: RTL

Time-slot arbiter for the single external SRAM port of the Oric core. Each 1 MHz CPU cycle is split into a phi1 slot (ULA video fetch) and a phi2 slot (6502 access). A third requester, the host image loader, writes tape/disk images into RAM through whichever slot its owner leaves unused. The block drives `ram_ad/ram_d/ram_cs/ram_oe/ram_we`, registers read data per requester and acknowledges loader writes.

---
 rtl/oric_ram_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/oric_ram_arbiter.sv
// oric_ram_arbiter: time-slot arbiter sharing one SRAM port between ULA video (phi1),
// the 6502 (phi2) and a host image loader that fills whichever slot is left unused.
`default_nettype none

module oric_ram_arbiter #(
    parameter int HALF_LEN = 12,
    parameter int RAM_LAT  = 2
) (
    input  logic        CLK_IN,
    input  logic        RESETn,
    input  logic        phase_start,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic [7:0]  vid_q,
    output logic        vid_valid,
    input  logic        cpu_req,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_do,
    output logic [7:0]  cpu_q,
    output logic        cpu_valid,
    input  logic        ld_req,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_ack,
    output logic [15:0] ram_ad,
    output logic [7:0]  ram_d,
    input  logic [7:0]  ram_q,
    output logic        ram_cs,
    output logic        ram_oe,
    output logic        ram_we
);

    localparam int CNT_W  = $clog2(2 * HALF_LEN);
    localparam int WAIT_W = $clog2(RAM_LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(2 * HALF_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_B    = CNT_W'(HALF_LEN);
    localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(RAM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_WAIT, A_DONE, B_SETUP, B_WAIT, B_DONE
    } state_t;

    typedef enum logic [1:0] {OWN_VID, OWN_CPU, OWN_LD} owner_t;

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WAIT_W-1:0]  wcnt_q, wcnt_d;
    logic               rd_q, rd_d;
    logic [15:0]        ad_q, ad_d;
    logic [7:0]         wd_q, wd_d;
    logic               cs_q, cs_d, oe_q, oe_d, we_q, we_d;
    logic [7:0]         vdat_q, vdat_d, cdat_q, cdat_d;
    logic               vval_q, vval_d, cval_q, cval_d, ack_q, ack_d;
    logic               slot_a, grant;

    always_ff @(posedge CLK_IN or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            owner_q <= OWN_VID;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            rd_q    <= 1'b0;
            ad_q    <= '0;
            wd_q    <= '0;
            cs_q    <= 1'b0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            vdat_q  <= '0;
            cdat_q  <= '0;
            vval_q  <= 1'b0;
            cval_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            rd_q    <= rd_d;
            ad_q    <= ad_d;
            wd_q    <= wd_d;
            cs_q    <= cs_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            vdat_q  <= vdat_d;
            cdat_q  <= cdat_d;
            vval_q  <= vval_d;
            cval_q  <= cval_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wcnt_d  = wcnt_q;
        rd_d    = rd_q;
        ad_d    = ad_q;
        wd_d    = wd_q;
        cs_d    = cs_q;
        oe_d    = oe_q;
        we_d    = we_q;
        vdat_d  = vdat_q;
        cdat_d  = cdat_q;
        vval_d  = 1'b0;
        cval_d  = 1'b0;
        ack_d   = 1'b0;
        grant   = 1'b0;
        slot_a  = (state_q == A_SETUP) || (state_q == A_WAIT) || (state_q == A_DONE);

        if (phase_start)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;

        // A new phi1 always wins: any access still in flight is abandoned silently.
        if (phase_start) begin
            state_d = A_SETUP;
            cs_d    = 1'b0;
            oe_d    = 1'b0;
            we_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cnt_d == CNT_B)
                        state_d = B_SETUP;
                end
                A_SETUP, B_SETUP: begin
                    if (slot_a ? vid_req : cpu_req) begin
                        grant   = 1'b1;
                        owner_d = slot_a ? OWN_VID : OWN_CPU;
                        rd_d    = slot_a ? 1'b1 : cpu_rw;
                        ad_d    = slot_a ? vid_addr : cpu_addr;
                        if (!slot_a && !cpu_rw)
                            wd_d = cpu_do;
                    end else if (ld_req) begin
                        grant   = 1'b1;
                        owner_d = OWN_LD;
                        rd_d    = 1'b0;
                        ad_d    = ld_addr;
                        wd_d    = ld_data;
                    end
                    cs_d    = grant;
                    oe_d    = grant && rd_d;
                    we_d    = grant && !rd_d;
                    wcnt_d  = '0;
                    state_d = !grant ? IDLE : (slot_a ? A_WAIT : B_WAIT);
                end
                A_WAIT, B_WAIT: begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == WAIT_END)
                        state_d = slot_a ? A_DONE : B_DONE;
                end
                A_DONE, B_DONE: begin
                    cs_d    = 1'b0;
                    oe_d    = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                    if (rd_q && owner_q == OWN_VID) begin
                        vdat_d = ram_q;
                        vval_d = 1'b1;
                    end else if (rd_q && owner_q == OWN_CPU) begin
                        cdat_d = ram_q;
                        cval_d = 1'b1;
                    end else if (!rd_q && owner_q == OWN_LD) begin
                        ack_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ram_ad    = ad_q;
    assign ram_d     = wd_q;
    assign ram_cs    = cs_q;
    assign ram_oe    = oe_q;
    assign ram_we    = we_q;
    assign vid_q     = vdat_q;
    assign vid_valid = vval_q;
    assign cpu_q     = cdat_q;
    assign cpu_valid = cval_q;
    assign ld_ack    = ack_q;

endmodule

`default_nettype wire
